decode_rf: RTL and testbench
============================

Name: decode_rf

Overview:
- Parametrised second-generation decode stage for the RV32I/RV32E core.
- Latches the fetched PC, instruction and valid bit, honouring stall and flush.
- Extracts opcode, funct3, funct7 and register fields, and generates a correctly sign-extended immediate per instruction format.
- Holds the architectural register file, with a configurable register count, and sits between fetch (I_*) and execute, with write-back arriving from the memory stage (M_*).

Parameters:
- XLEN, 32, data-path width in bits; PC, instruction, register and immediate width (instruction always 32).
- REG_NUM, 32, number of architectural registers; 32 (RV32I) or 16 (RV32E); x0 is hard-wired zero.
- RESET_PC, 32'h0000_0000, value of D_PC after reset or flush.

Ports:
- CLK  in  1  clock, all state updates on rising edge
- RST  in  1  synchronous, active-high reset
- STALL  in  1  hold pipeline latch; block register write-back
- FLUSH  in  1  squash latched instruction (branch/jump redirect)
- I_PC  in  XLEN  fetched PC
- I_INST  in  32  fetched instruction
- I_VALID  in  1  fetched instruction valid
- M_VALID  in  1  write-back request valid
- M_REG_D  in  5  write-back destination index
- M_REG_D_V  in  XLEN  write-back data
- D_PC  out  XLEN  latched PC
- D_INST  out  32  latched instruction
- D_VALID  out  1  latched valid
- D_OPCODE  out  7  inst[6:0]
- D_FUNCT3  out  3  inst[14:12]
- D_FUNCT7  out  7  inst[31:25]
- D_IMM  out  XLEN  sign-extended immediate
- D_REG_D  out  5  inst[11:7]
- D_REG_S1  out  5  inst[19:15]
- D_REG_S1_V  out  XLEN  rs1 value
- D_REG_S2  out  5  inst[24:20]
- D_REG_S2_V  out  XLEN  rs2 value
- D_ILLEGAL  out  1  unsupported opcode or register index >= REG_NUM, qualified by D_VALID
- REGS  out  XLEN*REG_NUM  flattened debug view; slice k is xk; slice 0 is always 0

Behaviour:
- Latch priority each edge: RST > FLUSH > STALL > load.
  - RST or FLUSH: D_PC=RESET_PC, D_INST=32'h0000_0013 (NOP), D_VALID=0.
  - STALL: hold all latched values.
  - Otherwise: load I_PC, I_INST, I_VALID.
- Latency: one cycle from I_* to D_*. Field outputs and the register read are combinational from the latch.
- Immediates, inst[31] replicated to XLEN:
  - I (opcodes 1100111, 0000011, 0010011, 0001111, 1110011): {sext, inst[31:20]}.
  - S (0100011): {sext, inst[31:25], inst[11:7]}.
  - B (1100011): {sext, inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - U (0110111, 0010111): {inst[31:12], 12'b0}, sign-extended if XLEN > 32.
  - J (1101111): {sext, inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - R (0110011) and all unknown opcodes: 0.
- Unknown opcode: D_ILLEGAL=1 when D_VALID=1.
- Register file reset: RST clears all registers to 0. The reset-value column of every output is defined by the latch values above.
- Write-back: on an edge with M_VALID=1, STALL=0 and RST=0, write M_REG_D_V to x[M_REG_D]; FLUSH does not block write-back.
  - Writes with M_REG_D=0 or M_REG_D >= REG_NUM are discarded.
- Read: index 0 or index >= REG_NUM returns 0. A used rs/rd index >= REG_NUM sets D_ILLEGAL (RV32E).
- Same-cycle write and read of the same register without the bypass below: the read returns the old value; the new value is visible the next cycle.
- Reset asserted mid-stall: reset wins, and STALL is ignored that cycle.

Optional Feature:
- Macro DECODE_RF_BYPASS_EN.
- Defined: when M_VALID=1, STALL=0 and M_REG_D equals a nonzero in-range D_REG_S1 or D_REG_S2, the corresponding *_V output returns M_REG_D_V combinationally (write-through).
- Undefined: no bypass; the hazard is resolved externally by stall or forwarding.

Decomposition:
- Package decode_rf_pkg:
  - Opcode constants (OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_REG, OP_FENCE, OP_SYSTEM).
  - NOP encoding 32'h0000_0013.
  - Immediate-format enum (IMM_R, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J).
- One natural sub-module: regfile.
  - Parametrised XLEN/REG_NUM; two read ports, one write port, x0 hard-zero, flattened debug bus.
  - The bypass mux lives inside regfile.

Test Plan:
- Reset, then I_INST=32'hFFF00093 (addi x1,x0,-1), I_VALID=1 -> next cycle D_VALID=1, D_IMM=32'hFFFFFFFF, D_REG_D=1, D_OPCODE=7'b0010011.
- Branch 32'hFE000EE3 (beq x0,x0,-4) -> D_IMM=32'hFFFFFFFC. JAL 32'h0000006F -> D_IMM=0. LUI 32'h12345037 -> D_IMM=32'h12345000.
- M_VALID=1, M_REG_D=5, M_REG_D_V=32'hDEADBEEF, STALL=0, then latch an instruction with rs1=5 -> D_REG_S1_V=32'hDEADBEEF. Repeat with STALL=1 -> register unchanged. Write to x0 -> REGS[XLEN-1:0] stays 0.
- STALL=1 for 3 cycles while I_* changes -> D_PC/D_INST held. FLUSH=1 together with STALL=1 -> D_VALID=0, D_INST=32'h00000013.
- REG_NUM=16: write to x20 ignored; instruction with rs2=17 -> D_REG_S2_V=0, D_ILLEGAL=1. Opcode 7'b1111111 -> D_ILLEGAL=1.
- DECODE_RF_BYPASS_EN defined: same-cycle write of x7=32'h55 while D_REG_S1=7 -> D_REG_S1_V=32'h55 in that cycle. Undefined: old value in that cycle, 32'h55 the next cycle.

Source files
------------

// File: rtl/decode_rf_pkg.sv
// Shared decode definitions: RV32 base opcodes, the canonical NOP and
// immediate-format classification used by decode_rf.
package decode_rf_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [2:0] {
    IMM_R,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_fmt_e;

  // Unknown opcodes fall into IMM_R so they produce a zero immediate.
  function automatic imm_fmt_e imm_fmt_of(input logic [6:0] op);
    imm_fmt_e fmt;
    case (op)
      OP_JALR, OP_LOAD, OP_IMM, OP_FENCE, OP_SYSTEM: fmt = IMM_I;
      OP_STORE:                                      fmt = IMM_S;
      OP_BRANCH:                                     fmt = IMM_B;
      OP_LUI, OP_AUIPC:                              fmt = IMM_U;
      OP_JAL:                                        fmt = IMM_J;
      default:                                       fmt = IMM_R;
    endcase
    return fmt;
  endfunction

  function automatic logic op_known(input logic [6:0] op);
    return op inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD,
                      OP_STORE, OP_IMM, OP_REG, OP_FENCE, OP_SYSTEM};
  endfunction

endpackage

// File: rtl/decode_rf_if.sv
// Decode-stage bus: fetch inputs, memory-stage write-back, pipeline control
// and the decoded outputs. master = surrounding pipeline, slave = decode_rf.
interface decode_rf_if #(
  parameter int XLEN    = 32,
  parameter int REG_NUM = 32
);
  logic                    STALL;
  logic                    FLUSH;
  logic [XLEN-1:0]         I_PC;
  logic [31:0]             I_INST;
  logic                    I_VALID;
  logic                    M_VALID;
  logic [4:0]              M_REG_D;
  logic [XLEN-1:0]         M_REG_D_V;
  logic [XLEN-1:0]         D_PC;
  logic [31:0]             D_INST;
  logic                    D_VALID;
  logic [6:0]              D_OPCODE;
  logic [2:0]              D_FUNCT3;
  logic [6:0]              D_FUNCT7;
  logic [XLEN-1:0]         D_IMM;
  logic [4:0]              D_REG_D;
  logic [4:0]              D_REG_S1;
  logic [XLEN-1:0]         D_REG_S1_V;
  logic [4:0]              D_REG_S2;
  logic [XLEN-1:0]         D_REG_S2_V;
  logic                    D_ILLEGAL;
  logic [XLEN*REG_NUM-1:0] REGS;

  modport master (
    output STALL, FLUSH, I_PC, I_INST, I_VALID, M_VALID, M_REG_D, M_REG_D_V,
    input  D_PC, D_INST, D_VALID, D_OPCODE, D_FUNCT3, D_FUNCT7, D_IMM,
           D_REG_D, D_REG_S1, D_REG_S1_V, D_REG_S2, D_REG_S2_V, D_ILLEGAL, REGS
  );

  modport slave (
    input  STALL, FLUSH, I_PC, I_INST, I_VALID, M_VALID, M_REG_D, M_REG_D_V,
    output D_PC, D_INST, D_VALID, D_OPCODE, D_FUNCT3, D_FUNCT7, D_IMM,
           D_REG_D, D_REG_S1, D_REG_S1_V, D_REG_S2, D_REG_S2_V, D_ILLEGAL, REGS
  );
endinterface

// File: rtl/decode_rf_regfile.sv
// Architectural register file: 2 read ports, 1 write port, x0 hard zero.
// DECODE_RF_BYPASS_EN: a same-cycle write is forwarded to matching read ports.
module decode_rf_regfile #(
  parameter int XLEN    = 32,
  parameter int REG_NUM = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic [4:0]              waddr,
  input  logic [XLEN-1:0]         wdata,
  input  logic [4:0]              raddr1,
  input  logic [4:0]              raddr2,
  output logic [XLEN-1:0]         rdata1,
  output logic [XLEN-1:0]         rdata2,
  output logic [XLEN*REG_NUM-1:0] regs_flat
);
  localparam int         AW      = $clog2(REG_NUM);
  localparam logic [5:0] REG_LIM = 6'(REG_NUM);

  logic [XLEN-1:0] regs_d [REG_NUM];
  logic [XLEN-1:0] regs_q [REG_NUM];
  logic            wr_ok;

  // Index refers to a real, writable register (not x0, not beyond REG_NUM).
  function automatic logic live(input logic [4:0] idx);
    return (idx != 5'd0) && ({1'b0, idx} < REG_LIM);
  endfunction

  assign wr_ok = we & live(waddr);

  always_comb begin
    regs_d = regs_q;
    if (wr_ok) regs_d[waddr[AW-1:0]] = wdata;
    regs_d[0] = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) regs_q <= '{default: '0};
    else     regs_q <= regs_d;
  end

  always_comb begin
    rdata1 = live(raddr1) ? regs_q[raddr1[AW-1:0]] : '0;
    rdata2 = live(raddr2) ? regs_q[raddr2[AW-1:0]] : '0;
`ifdef DECODE_RF_BYPASS_EN
    if (wr_ok && (waddr == raddr1)) rdata1 = wdata;
    if (wr_ok && (waddr == raddr2)) rdata2 = wdata;
`else
`endif
  end

  for (genvar k = 0; k < REG_NUM; k++) begin : g_flat
    assign regs_flat[k*XLEN +: XLEN] = regs_q[k];
  end

endmodule

// File: rtl/decode_rf.sv
// RV32I/RV32E decode stage: pipeline latch, field/immediate decode, register file.
// Optional macro DECODE_RF_BYPASS_EN enables write-through in the register file.
module decode_rf
  import decode_rf_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              REG_NUM  = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic        CLK,
  input  logic        RST,
  decode_rf_if.slave  bus
);
  localparam logic [5:0] REG_LIM = 6'(REG_NUM);

  logic [XLEN-1:0] pc_d, pc_q;
  logic [31:0]     inst_d, inst_q;
  logic            valid_d, valid_q;
  logic [31:0]     imm32;
  imm_fmt_e        fmt;
  logic            known, uses_rd, uses_rs1, uses_rs2;
  logic            rd_bad, rs1_bad, rs2_bad;

  always_comb begin
    pc_d    = pc_q;
    inst_d  = inst_q;
    valid_d = valid_q;
    if (bus.FLUSH) begin
      pc_d    = RESET_PC;
      inst_d  = NOP_INST;
      valid_d = 1'b0;
    end else if (!bus.STALL) begin
      pc_d    = bus.I_PC;
      inst_d  = bus.I_INST;
      valid_d = bus.I_VALID;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pc_q    <= RESET_PC;
      inst_q  <= NOP_INST;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      valid_q <= valid_d;
    end
  end

  assign fmt   = imm_fmt_of(inst_q[6:0]);
  assign known = op_known(inst_q[6:0]);

  always_comb begin
    imm32 = '0;
    case (fmt)
      IMM_I:   imm32 = {{20{inst_q[31]}}, inst_q[31:20]};
      IMM_S:   imm32 = {{20{inst_q[31]}}, inst_q[31:25], inst_q[11:7]};
      IMM_B:   imm32 = {{19{inst_q[31]}}, inst_q[31], inst_q[7], inst_q[30:25],
                        inst_q[11:8], 1'b0};
      IMM_U:   imm32 = {inst_q[31:12], 12'b0};
      IMM_J:   imm32 = {{11{inst_q[31]}}, inst_q[31], inst_q[19:12], inst_q[20],
                        inst_q[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  // Only fields the format actually uses may flag an out-of-range register.
  assign uses_rd  = known & (fmt inside {IMM_R, IMM_I, IMM_U, IMM_J});
  assign uses_rs1 = known & (fmt inside {IMM_R, IMM_I, IMM_S, IMM_B});
  assign uses_rs2 = known & (fmt inside {IMM_R, IMM_S, IMM_B});
  assign rd_bad   = {1'b0, inst_q[11:7]}  >= REG_LIM;
  assign rs1_bad  = {1'b0, inst_q[19:15]} >= REG_LIM;
  assign rs2_bad  = {1'b0, inst_q[24:20]} >= REG_LIM;

  assign bus.D_PC      = pc_q;
  assign bus.D_INST    = inst_q;
  assign bus.D_VALID   = valid_q;
  assign bus.D_OPCODE  = inst_q[6:0];
  assign bus.D_FUNCT3  = inst_q[14:12];
  assign bus.D_FUNCT7  = inst_q[31:25];
  assign bus.D_REG_D   = inst_q[11:7];
  assign bus.D_REG_S1  = inst_q[19:15];
  assign bus.D_REG_S2  = inst_q[24:20];
  assign bus.D_IMM     = XLEN'(signed'(imm32));
  assign bus.D_ILLEGAL = valid_q & (~known | (uses_rd & rd_bad) |
                                    (uses_rs1 & rs1_bad) | (uses_rs2 & rs2_bad));

  decode_rf_regfile #(
    .XLEN    (XLEN),
    .REG_NUM (REG_NUM)
  ) u_regfile (
    .clk       (CLK),
    .rst       (RST),
    .we        (bus.M_VALID & ~bus.STALL),
    .waddr     (bus.M_REG_D),
    .wdata     (bus.M_REG_D_V),
    .raddr1    (inst_q[19:15]),
    .raddr2    (inst_q[24:20]),
    .rdata1    (bus.D_REG_S1_V),
    .rdata2    (bus.D_REG_S2_V),
    .regs_flat (bus.REGS)
  );

endmodule

// File: tb/tb_decode_rf.sv
// Self-checking bench for decode_rf: RV32I (32 regs) and RV32E (16 regs) side by side.
module tb_decode_rf;

  logic CLK = 1'b0;
  logic RST;
  logic stall, flush, ivalid, mvalid;
  logic [31:0] ipc, iinst, mdata;
  logic [4:0] mrd;

  int checks   = 0;
  int failures = 0;

  decode_rf_if #(.XLEN(32), .REG_NUM(32)) if32 ();
  decode_rf_if #(.XLEN(32), .REG_NUM(16)) if16 ();

  assign if32.STALL = stall;   assign if16.STALL = stall;
  assign if32.FLUSH = flush;   assign if16.FLUSH = flush;
  assign if32.I_PC = ipc;      assign if16.I_PC = ipc;
  assign if32.I_INST = iinst;  assign if16.I_INST = iinst;
  assign if32.I_VALID = ivalid; assign if16.I_VALID = ivalid;
  assign if32.M_VALID = mvalid; assign if16.M_VALID = mvalid;
  assign if32.M_REG_D = mrd;   assign if16.M_REG_D = mrd;
  assign if32.M_REG_D_V = mdata; assign if16.M_REG_D_V = mdata;

  decode_rf #(.XLEN(32), .REG_NUM(32), .RESET_PC(32'h0)) dut32 (
    .CLK(CLK), .RST(RST), .bus(if32.slave));
  decode_rf #(.XLEN(32), .REG_NUM(16), .RESET_PC(32'h0)) dut16 (
    .CLK(CLK), .RST(RST), .bus(if16.slave));

  always #5 CLK = ~CLK;

  // Reference model state
  logic [31:0] m_pc, m_inst;
  logic        m_valid;
  logic [31:0] rf32 [32];
  logic [31:0] rf16 [16];

  function automatic logic [31:0] exp_imm(input logic [31:0] i);
    int s;
    s = i;
    case (i[6:0])
      7'b1100111, 7'b0000011, 7'b0010011, 7'b0001111, 7'b1110011:
        return 32'(s >>> 20);
      7'b0100011:
        return 32'((s >>> 25) * 32) | 32'(i[11:7]);
      7'b1100011:
        return 32'((s >>> 31) * 4096) | (32'(i[7]) << 11) | (32'(i[30:25]) << 5)
               | (32'(i[11:8]) << 1);
      7'b0110111, 7'b0010111:
        return i & 32'hFFFF_F000;
      7'b1101111:
        return 32'((s >>> 31) * 1048576) | (32'(i[19:12]) << 12) | (32'(i[20]) << 11)
               | (32'(i[30:21]) << 1);
      default:
        return 32'h0;
    endcase
  endfunction

  function automatic logic exp_ill(input logic [31:0] i, input logic v, input int n);
    logic known, urd, urs1, urs2;
    known = 1'b1; urd = 1'b0; urs1 = 1'b0; urs2 = 1'b0;
    case (i[6:0])
      7'b0110111, 7'b0010111, 7'b1101111: urd = 1'b1;
      7'b1100111, 7'b0000011, 7'b0010011, 7'b0001111, 7'b1110011: begin
        urd = 1'b1; urs1 = 1'b1;
      end
      7'b0100011, 7'b1100011: begin urs1 = 1'b1; urs2 = 1'b1; end
      7'b0110011: begin urd = 1'b1; urs1 = 1'b1; urs2 = 1'b1; end
      default: known = 1'b0;
    endcase
    return v && (!known || (urd && int'(i[11:7]) >= n) ||
                 (urs1 && int'(i[19:15]) >= n) || (urs2 && int'(i[24:20]) >= n));
  endfunction

  function automatic logic [31:0] exp_rd(input logic [4:0] idx, input int n);
    if (idx == 5'd0 || int'(idx) >= n) return 32'h0;
`ifdef DECODE_RF_BYPASS_EN
    if (mvalid && !stall && mrd == idx) return mdata;
`endif
    if (n == 32) return rf32[idx];
    return rf16[idx[3:0]];
  endfunction

  task automatic model_edge();
    if (RST) begin
      m_pc = 32'h0; m_inst = 32'h13; m_valid = 1'b0;
      for (int k = 0; k < 32; k++) rf32[k] = 32'h0;
      for (int k = 0; k < 16; k++) rf16[k] = 32'h0;
    end else begin
      if (flush) begin
        m_pc = 32'h0; m_inst = 32'h13; m_valid = 1'b0;
      end else if (!stall) begin
        m_pc = ipc; m_inst = iinst; m_valid = ivalid;
      end
      if (mvalid && !stall && mrd != 5'd0) begin
        rf32[mrd] = mdata;
        if (mrd < 5'd16) rf16[mrd[3:0]] = mdata;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic check_dut(input string tag, input int n,
      input logic [31:0] pc, input logic [31:0] inst, input logic valid,
      input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
      input logic [31:0] imm, input logic [4:0] rd, input logic [4:0] rs1,
      input logic [4:0] rs2, input logic [31:0] v1, input logic [31:0] v2,
      input logic ill, input logic [1023:0] regs);
    logic [1023:0] e;
    chk({tag, "_pc"}, pc, m_pc);
    chk({tag, "_inst"}, inst, m_inst);
    chk({tag, "_valid"}, 32'(valid), 32'(m_valid));
    chk({tag, "_opcode"}, 32'(opc), 32'(m_inst[6:0]));
    chk({tag, "_funct3"}, 32'(f3), 32'(m_inst[14:12]));
    chk({tag, "_funct7"}, 32'(f7), 32'(m_inst[31:25]));
    chk({tag, "_imm"}, imm, exp_imm(m_inst));
    chk({tag, "_rd"}, 32'(rd), 32'(m_inst[11:7]));
    chk({tag, "_rs1"}, 32'(rs1), 32'(m_inst[19:15]));
    chk({tag, "_rs2"}, 32'(rs2), 32'(m_inst[24:20]));
    chk({tag, "_rs1_v"}, v1, exp_rd(m_inst[19:15], n));
    chk({tag, "_rs2_v"}, v2, exp_rd(m_inst[24:20], n));
    chk({tag, "_illegal"}, 32'(ill), 32'(exp_ill(m_inst, m_valid, n)));
    e = '0;
    for (int k = 1; k < n; k++) begin
      if (n == 32) e[k*32 +: 32] = rf32[k];
      else         e[k*32 +: 32] = rf16[k];
    end
    checks++;
    if (regs !== e) begin
      failures++;
      for (int k = 0; k < 32; k++)
        if (regs[k*32 +: 32] !== e[k*32 +: 32]) begin
          $display("FAIL %s_regs x%0d actual=%h expected=%h", tag, k,
                   regs[k*32 +: 32], e[k*32 +: 32]);
          break;
        end
    end
  endtask

  task automatic check_all();
    check_dut("r32", 32, if32.D_PC, if32.D_INST, if32.D_VALID, if32.D_OPCODE,
              if32.D_FUNCT3, if32.D_FUNCT7, if32.D_IMM, if32.D_REG_D, if32.D_REG_S1,
              if32.D_REG_S2, if32.D_REG_S1_V, if32.D_REG_S2_V, if32.D_ILLEGAL,
              1024'(if32.REGS));
    check_dut("r16", 16, if16.D_PC, if16.D_INST, if16.D_VALID, if16.D_OPCODE,
              if16.D_FUNCT3, if16.D_FUNCT7, if16.D_IMM, if16.D_REG_D, if16.D_REG_S1,
              if16.D_REG_S2, if16.D_REG_S1_V, if16.D_REG_S2_V, if16.D_ILLEGAL,
              1024'(if16.REGS));
  endtask

  task automatic step();
    model_edge();
    @(posedge CLK);
    #1;
    check_all();
  endtask

  typedef struct {
    logic [31:0] inst;
    logic [31:0] imm;
    logic        ill32;
    logic        ill16;
  } vec_t;

  vec_t vecs [12];
  logic [6:0] ops [11];

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{32'hFFF00093, 32'hFFFF_FFFF, 1'b0, 1'b0}; // addi x1,x0,-1
    vecs[1]  = '{32'hFE000EE3, 32'hFFFF_FFFC, 1'b0, 1'b0}; // beq x0,x0,-4
    vecs[2]  = '{32'h0000006F, 32'h0000_0000, 1'b0, 1'b0}; // jal x0,0
    vecs[3]  = '{32'h12345037, 32'h1234_5000, 1'b0, 1'b0}; // lui x0
    vecs[4]  = '{32'h0021A423, 32'h0000_0008, 1'b0, 1'b0}; // sw x2,8(x3)
    vecs[5]  = '{32'hFE21AE23, 32'hFFFF_FFFC, 1'b0, 1'b0}; // sw x2,-4(x3)
    vecs[6]  = '{32'h80000297, 32'h8000_0000, 1'b0, 1'b0}; // auipc x5
    vecs[7]  = '{32'h011100B3, 32'h0000_0000, 1'b0, 1'b1}; // add x1,x2,x17
    vecs[8]  = '{32'h0000007F, 32'h0000_0000, 1'b1, 1'b1}; // opcode 1111111
    vecs[9]  = '{32'h800A00E7, 32'hFFFF_F800, 1'b0, 1'b1}; // jalr x1,-2048(x20)
    vecs[10] = '{32'hFFDFF0EF, 32'hFFFF_FFFC, 1'b0, 1'b0}; // jal x1,-4
    vecs[11] = '{32'h00209863, 32'h0000_0010, 1'b0, 1'b0}; // bne x1,x2,16
    ops = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011, 7'b0000011,
            7'b0100011, 7'b0010011, 7'b0110011, 7'b0001111, 7'b1110011};

    stall = 0; flush = 0; ivalid = 0; ipc = 0; iinst = 32'h13;
    mvalid = 0; mrd = 0; mdata = 0;
    RST = 1;
    step();
    chk("reset_valid", 32'(if32.D_VALID), 32'h0);
    chk("reset_inst", if32.D_INST, 32'h13);
    chk("reset_pc", if32.D_PC, 32'h0);
    RST = 0;

    // addi x1,x0,-1 lands one cycle later
    ipc = 32'h40; iinst = 32'hFFF00093; ivalid = 1;
    step();
    chk("addi_valid", 32'(if32.D_VALID), 32'h1);
    chk("addi_imm", if32.D_IMM, 32'hFFFF_FFFF);
    chk("addi_rd", 32'(if32.D_REG_D), 32'h1);
    chk("addi_opcode", 32'(if32.D_OPCODE), 32'h13);

    for (int i = 0; i < 12; i++) begin
      ipc = 32'h100 + 32'(i * 4); iinst = vecs[i].inst; ivalid = 1;
      step();
      chk($sformatf("tbl%0d_imm", i), if32.D_IMM, vecs[i].imm);
      chk($sformatf("tbl%0d_ill32", i), 32'(if32.D_ILLEGAL), 32'(vecs[i].ill32));
      chk($sformatf("tbl%0d_ill16", i), 32'(if16.D_ILLEGAL), 32'(vecs[i].ill16));
    end

    // write-back then read through rs1
    mvalid = 1; mrd = 5; mdata = 32'hDEADBEEF; iinst = 32'h00028313;
    step();
    mvalid = 0;
    step();
    chk("wb_rs1_v", if32.D_REG_S1_V, 32'hDEADBEEF);
    stall = 1; mvalid = 1; mdata = 32'h1234_5678;
    step();
    chk("stall_blocks_wb", if32.REGS[5*32 +: 32], 32'hDEADBEEF);
    stall = 0; mrd = 0; mdata = 32'hFFFF_FFFF;
    step();
    chk("x0_zero", if32.REGS[31:0], 32'h0);
    mvalid = 0;

    // stall hold for three cycles
    ipc = 32'h200; iinst = 32'h00209863;
    step();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      ipc = $urandom & 32'hFFFF_FFFC; iinst = $urandom;
      step();
      chk("stall_pc", if32.D_PC, 32'h200);
      chk("stall_inst", if32.D_INST, 32'h00209863);
    end
    flush = 1;
    step();
    chk("flush_valid", 32'(if32.D_VALID), 32'h0);
    chk("flush_inst", if32.D_INST, 32'h13);
    flush = 0; stall = 0;

    // RV32E: x20 write dropped, rs2=x17 reads zero and is illegal
    mvalid = 1; mrd = 20; mdata = 32'hAAAA_5555;
    step();
    chk("x20_r32", if32.REGS[20*32 +: 32], 32'hAAAA_5555);
    mrd = 17; mdata = 32'h0000_1717;
    step();
    mvalid = 0; iinst = 32'h011100B3; ivalid = 1;
    step();
    chk("e_rs2_v", if16.D_REG_S2_V, 32'h0);
    chk("e_illegal", 32'(if16.D_ILLEGAL), 32'h1);
    chk("i_rs2_v", if32.D_REG_S2_V, 32'h0000_1717);

    // same-cycle write and read of x7
    mvalid = 1; mrd = 7; mdata = 32'h11; iinst = 32'h00038013;
    step();
    mvalid = 0;
    step();
    mvalid = 1; mdata = 32'h55;
    #1;
    check_all();
`ifdef DECODE_RF_BYPASS_EN
    chk("byp_same_cycle", if32.D_REG_S1_V, 32'h55);
`else
    chk("byp_same_cycle", if32.D_REG_S1_V, 32'h11);
`endif
    step();
    chk("byp_next_cycle", if32.D_REG_S1_V, 32'h55);
    mvalid = 0;

    // reset wins over stall
    stall = 1; RST = 1; mvalid = 1; mrd = 3; mdata = 32'h3333;
    step();
    chk("rst_stall_valid", 32'(if32.D_VALID), 32'h0);
    chk("rst_stall_x5", if32.REGS[5*32 +: 32], 32'h0);
    chk("rst_stall_x3", if32.REGS[3*32 +: 32], 32'h0);
    RST = 0; stall = 0; mvalid = 0;

    for (int it = 0; it < 400; it++) begin
      RST    = ($urandom_range(0, 39) == 0);
      stall  = ($urandom_range(0, 3) == 0);
      flush  = ($urandom_range(0, 7) == 0);
      ivalid = $urandom_range(0, 1);
      ipc    = $urandom & 32'hFFFF_FFFC;
      iinst  = $urandom;
      if ($urandom_range(0, 3) != 0) iinst[6:0] = ops[$urandom_range(0, 10)];
      mvalid = $urandom_range(0, 1);
      mrd    = 5'($urandom);
      mdata  = $urandom;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
